// File: rtl/m_serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and default geometry.
package m_serial_adder_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/m_serial_adder_if.sv
// Operand/result handshake bundle for m_serial_adder.
// w_sub exists only when SERIAL_ADDER_SUB_EN is defined.
interface m_serial_adder_if
  import m_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             w_in_valid;
  logic             w_in_ready;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             w_sub;
`endif
  logic             w_out_valid;
  logic             w_out_ready;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_busy;

  modport master (
    output w_in_valid, w_a, w_b, w_cin,
`ifdef SERIAL_ADDER_SUB_EN
    output w_sub,
`endif
    output w_out_ready,
    input  w_in_ready, w_out_valid, w_sum, w_cout, w_busy
  );

  modport slave (
    input  w_in_valid, w_a, w_b, w_cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  w_sub,
`endif
    input  w_out_ready,
    output w_in_ready, w_out_valid, w_sum, w_cout, w_busy
  );

endinterface

// File: rtl/m_chunk_adder.sv
// CHUNK-bit combinational ripple-carry adder built from full-adder cells.
module m_chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/m_serial_adder.sv
// Multi-cycle unsigned adder: CHUNK bits per RUN cycle, valid/ready on both sides.
// Define SERIAL_ADDER_SUB_EN to add the w_sub port (A-B via ~B + 1).
module m_serial_adder
  import m_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input logic             w_clk,
  input logic             w_rst,
  m_serial_adder_if.slave bus
);

  localparam int NSTEP = WIDTH / CHUNK;
  localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSTEP - 1);

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_geometry
    $error("m_serial_adder: WIDTH must be >= 1 and a multiple of CHUNK");
  end

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_r, b_r;
  logic             carry_r;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic [WIDTH-1:0] b_load;
  logic             cin_load;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_c;
  logic [WIDTH-1:0] sum_shift;
  logic             accept, run, last_step;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is A + ~B + 1; the caller's carry-in has no meaning then.
  assign b_load   = bus.w_sub ? ~bus.w_b : bus.w_b;
  assign cin_load = bus.w_sub | bus.w_cin;
`else
  assign b_load   = bus.w_b;
  assign cin_load = bus.w_cin;
`endif

  assign accept    = (state == ST_IDLE) && bus.w_in_valid;
  assign run       = (state == ST_RUN);
  assign last_step = run && (cnt == LAST);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge w_clk) begin
    if (w_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (bus.w_in_valid)  state_next = ST_RUN;
      ST_RUN:  if (cnt == LAST)     state_next = ST_DONE;
      ST_DONE: if (bus.w_out_ready) state_next = ST_IDLE;
      default:                      state_next = ST_IDLE;
    endcase
  end

  m_chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_r[CHUNK-1:0]),
    .b    (b_r[CHUNK-1:0]),
    .cin  (carry_r),
    .s    (chunk_s),
    .cout (chunk_c)
  );

  // NOTE: operand/carry shift registers are not reset; they are always loaded at acceptance before use.
  always_ff @(posedge w_clk) begin
    if (accept) begin
      a_r     <= bus.w_a;
      b_r     <= b_load;
      carry_r <= cin_load;
    end else if (run) begin
      a_r     <= a_r >> CHUNK;
      b_r     <= b_r >> CHUNK;
      carry_r <= chunk_c;
    end
  end

  // Partial sum fills from the MSB side; with one step there is nothing to hold.
  if (NSTEP == 1) begin : g_single
    assign sum_shift = chunk_s;
  end else begin : g_multi
    logic [WIDTH-CHUNK-1:0] part_r;

    always_ff @(posedge w_clk) begin
      if (accept)   part_r <= '0;
      else if (run) part_r <= sum_shift[WIDTH-1:CHUNK];
    end

    assign sum_shift = {chunk_s, part_r};
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
      if (last_step) begin
        sum_q  <= sum_shift;
        cout_q <= chunk_c;
      end
    end
  end

  assign bus.w_in_ready  = (state == ST_IDLE);
  assign bus.w_out_valid = (state == ST_DONE);
  assign bus.w_busy      = (state == ST_RUN) || (state == ST_DONE);
  assign bus.w_sum       = sum_q;
  assign bus.w_cout      = cout_q;

endmodule

// File: tb/tb_m_serial_adder.sv
// Directed self-checking bench for m_serial_adder (CHUNK=4 and CHUNK=WIDTH instances).
module tb_m_serial_adder;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  m_serial_adder_if #(.WIDTH(W)) bus_a ();
  m_serial_adder_if #(.WIDTH(W)) bus_b ();

  m_serial_adder #(.WIDTH(W), .CHUNK(4)) dut_a (.w_clk(clk), .w_rst(rst), .bus(bus_a.slave));
  m_serial_adder #(.WIDTH(W), .CHUNK(8)) dut_b (.w_clk(clk), .w_rst(rst), .bus(bus_b.slave));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs [5] = '{
    '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, co: 1'b0},
    '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, co: 1'b1},
    '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, co: 1'b1},
    '{a: 8'h0F, b: 8'h01, cin: 1'b0, s: 8'h10, co: 1'b0},
    '{a: 8'h12, b: 8'h34, cin: 1'b0, s: 8'h46, co: 1'b0}
  };

  // Present operands at a falling edge; returns at the falling edge after acceptance.
  task automatic start_a(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub);
    check("in_ready_idle", bus_a.w_in_ready, 1);
    bus_a.w_in_valid = 1'b1;
    bus_a.w_a        = a;
    bus_a.w_b        = b;
    bus_a.w_cin      = cin;
`ifdef SERIAL_ADDER_SUB_EN
    bus_a.w_sub      = sub;
`else
    if (sub) $display("note: w_sub requested without SERIAL_ADDER_SUB_EN");
`endif
    @(negedge clk);
    bus_a.w_in_valid = 1'b0;
    bus_a.w_a        = ~a;
    bus_a.w_b        = ~b;
    bus_a.w_cin      = ~cin;
    check("busy_run", bus_a.w_busy, 1);
    check("in_ready_run", bus_a.w_in_ready, 0);
  endtask

  // Count edges since acceptance until w_out_valid, bounded.
  task automatic wait_a(input int n0, output int n);
    n = n0;
    while (!bus_a.w_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic release_a();
    bus_a.w_out_ready = 1'b1;
    @(negedge clk);
    bus_a.w_out_ready = 1'b0;
    check("idle_in_ready", bus_a.w_in_ready, 1);
    check("idle_out_valid", bus_a.w_out_valid, 0);
  endtask

  task automatic run_a(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub,
                       input logic [7:0] exp_s, input logic exp_c);
    int n;
    start_a(a, b, cin, sub);
    wait_a(1, n);
    check({tag, "_latency"}, n, 3);
    check({tag, "_sum"}, bus_a.w_sum, exp_s);
    check({tag, "_cout"}, bus_a.w_cout, exp_c);
    release_a();
  endtask

  initial begin
    int n;
    bus_a.w_in_valid = 1'b0; bus_a.w_a = '0; bus_a.w_b = '0; bus_a.w_cin = 1'b0;
    bus_a.w_out_ready = 1'b0;
    bus_b.w_in_valid = 1'b0; bus_b.w_a = '0; bus_b.w_b = '0; bus_b.w_cin = 1'b0;
    bus_b.w_out_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus_a.w_sub = 1'b0;
    bus_b.w_sub = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("rst_in_ready", bus_a.w_in_ready, 1);
    check("rst_out_valid", bus_a.w_out_valid, 0);
    check("rst_sum", bus_a.w_sum, 0);
    check("rst_cout", bus_a.w_cout, 0);
    check("rst_busy", bus_a.w_busy, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_a($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
            vecs[i].s, vecs[i].co);

    // Backpressure: result must hold for five stalled cycles.
    start_a(8'h5A, 8'h23, 1'b1, 1'b0);
    wait_a(1, n);
    check("bp_latency", n, 3);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", bus_a.w_out_valid, 1);
      check("bp_sum", bus_a.w_sum, 8'h7E);
      check("bp_cout", bus_a.w_cout, 0);
      check("bp_in_ready", bus_a.w_in_ready, 0);
      @(negedge clk);
    end
    release_a();
    check("bp_sum_kept", bus_a.w_sum, 8'h7E);

    // Operands offered during RUN are ignored.
    start_a(8'h12, 8'h34, 1'b0, 1'b0);
    bus_a.w_in_valid = 1'b1; bus_a.w_a = 8'hFF; bus_a.w_b = 8'hFF; bus_a.w_cin = 1'b1;
    @(negedge clk);
    bus_a.w_in_valid = 1'b0;
    wait_a(2, n);
    check("ign_latency", n, 3);
    check("ign_sum", bus_a.w_sum, 8'h46);
    check("ign_cout", bus_a.w_cout, 0);
    release_a();

    // Reset during the first RUN cycle discards the operation.
    start_a(8'hFF, 8'hFF, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", bus_a.w_in_ready, 1);
    check("midrst_out_valid", bus_a.w_out_valid, 0);
    check("midrst_sum", bus_a.w_sum, 0);
    check("midrst_cout", bus_a.w_cout, 0);
    check("midrst_busy", bus_a.w_busy, 0);
    repeat (3) @(negedge clk);
    check("midrst_no_valid", bus_a.w_out_valid, 0);
    run_a("post_rst", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    run_a("sub_borrow", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
    run_a("sub_noborrow", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1);
`endif

    // Single-step geometry: CHUNK == WIDTH.
    check("b_in_ready", bus_b.w_in_ready, 1);
    bus_b.w_in_valid = 1'b1; bus_b.w_a = 8'h80; bus_b.w_b = 8'h80; bus_b.w_cin = 1'b0;
    @(negedge clk);
    bus_b.w_in_valid = 1'b0; bus_b.w_a = 8'h00; bus_b.w_b = 8'h00;
    n = 1;
    while (!bus_b.w_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b_latency", n, 2);
    check("b_sum", bus_b.w_sum, 8'h00);
    check("b_cout", bus_b.w_cout, 1);
    bus_b.w_out_ready = 1'b1;
    @(negedge clk);
    bus_b.w_out_ready = 1'b0;
    check("b_idle", bus_b.w_in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/m_serial_adder.md
Name: m_serial_adder

Overview:
- Multi-cycle, parametrised unsigned adder. Adds two WIDTH-bit operands plus carry-in, processing CHUNK bits per clock through a carry-propagating chunk adder.
- Used where a full-width single-cycle ripple adder is too slow or too large.
- Operands enter through a valid/ready input handshake. The result leaves through a valid/ready output handshake.
- Intended as the arithmetic building block for later accumulator and ALU exercises.

Parameters:
- WIDTH, 8, operand and sum width in bits. Must be ≥1 and a multiple of CHUNK; other values are an elaboration-time error.
- CHUNK, 4, bits added per RUN cycle.
- Derived NSTEP = WIDTH/CHUNK, the number of RUN cycles per operation.

Ports:
- w_clk  input  1  clock, rising edge
- w_rst  input  1  reset, synchronous, active-high
- w_in_valid  input  1  operands present
- w_in_ready  output  1  block can accept operands
- w_a  input  WIDTH  operand A
- w_b  input  WIDTH  operand B
- w_cin  input  1  carry-in
- w_out_valid  output  1  result valid
- w_out_ready  input  1  consumer accepts result
- w_sum  output  WIDTH  sum, registered
- w_cout  output  1  final carry-out, registered
- w_busy  output  1  high in RUN or DONE

Behaviour:
- Reset:
  - Checked on w_clk rising edge; has priority over everything, including mid-RUN and mid-DONE.
  - Reset values: state=IDLE, w_in_ready=1, w_out_valid=0, w_sum=0, w_cout=0, w_busy=0, step counter=0. Any in-flight operation is discarded.
- Outputs are Moore: w_in_ready = (state==IDLE); w_out_valid = (state==DONE).
- IDLE:
  - Accept on w_in_valid & w_in_ready: latch a_r=w_a, b_r=w_b, carry_r=w_cin, clear sum_r, cnt=0; go to RUN.
  - If w_in_valid is low, stay in IDLE.
- RUN, each cycle:
  - {c, s} = a_r[CHUNK-1:0] + b_r[CHUNK-1:0] + carry_r.
  - sum_r = {s, sum_r[WIDTH-1:CHUNK]} (shift in from the MSB side).
  - a_r and b_r shift right by CHUNK. carry_r=c. cnt++.
  - When cnt==NSTEP-1: the final chunk is written, w_cout=c, and the state goes to DONE.
  - w_in_valid is ignored in RUN.
- DONE:
  - w_sum and w_cout stay stable while w_out_valid=1 and w_out_ready=0 (backpressure of any length).
  - On w_out_ready=1: go to IDLE next cycle. The result registers keep their values until the next completion.
- Latency: acceptance edge → w_out_valid high after exactly NSTEP+1 rising edges. Throughput: one operation per NSTEP+2 cycles.
- CHUNK==WIDTH: NSTEP=1; a single RUN cycle.
- Arithmetic is modulo 2^WIDTH. Overflow is reported only through w_cout.
- Operand changes on w_a/w_b/w_cin after acceptance have no effect.

Optional Feature:
- Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port w_sub (1 bit), latched at acceptance.
  - When w_sub=1, b_r is loaded as ~w_b and carry_r as 1. w_cin is ignored, so the result is A−B.
  - w_cout=1 means no borrow (A≥B).
- Undefined: port absent; addition only; the logic must be identical to the base design.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 is illegal and recovers to IDLE);
  - default WIDTH and CHUNK constants.
- One sub-module: m_chunk_adder (CHUNK-bit combinational ripple of full adders with carry in/out), instantiated once.

Test Plan:
- WIDTH=8, CHUNK=4: a=8'hFF, b=8'h01, cin=0 → after 3 edges w_out_valid=1, w_sum=8'h00, w_cout=1.
- a=8'h5A, b=8'h23, cin=1, with w_out_ready held 0 for 5 cycles → w_sum=8'h7E, w_cout=0, stable all 5 cycles; w_in_ready=0 throughout; back to IDLE one cycle after w_out_ready=1.
- w_rst asserted in the first RUN cycle of 8'hFF+8'hFF → next edge: IDLE, w_out_valid=0, w_sum=0, w_cout=0. A new 8'h01+8'h02 then yields 8'h03.
- CHUNK=WIDTH=8: 8'h80+8'h80 → w_out_valid after 2 edges, w_sum=8'h00, w_cout=1.
- w_in_valid pulsed with new operands during RUN → ignored; first result is unchanged.
- SERIAL_ADDER_SUB_EN, w_sub=1: 8'h05−8'h07 → w_sum=8'hFE, w_cout=0. Then 8'h07−8'h05 → w_sum=8'h02, w_cout=1.
